// File: rtl/sha_digest_serializer.sv
// sha_digest_serializer
//
// Output stage behind the SHA-256 core. Captures a finished 256-bit digest
// and streams it out one byte per valid/ready handshake, either as 32 raw
// bytes (MSB byte first) or as 64 lowercase ASCII hex characters (high
// nibble first), optionally followed by TERM_CHAR in hex mode.
//
// Parameters:
//   TERM_EN    - nonzero appends TERM_CHAR after the last hex character
//   TERM_CHAR  - terminator byte value
//
// Ports:
//   clk        - clock, all logic on rising edge
//   rst        - synchronous reset, active-low
//   digest_vld - single-cycle pulse, digest_in holds a finished digest
//   digest_in  - hash digest, H0 in [255:224]
//   hex_mode   - 0 = raw bytes, 1 = ASCII hex; sampled only at capture
//   out_data   - output byte (registered)
//   out_valid  - out_data valid (registered)
//   out_ready  - sink accepts out_data this cycle
//   out_last   - high with the final byte of a frame (registered)
//   busy       - frame in progress
//   drop_err   - sticky: a digest was discarded while busy

module sha_digest_serializer #(
    parameter int         TERM_EN   = 0,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         digest_vld,
    input  logic [255:0] digest_in,
    input  logic         hex_mode,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         drop_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2
    } state_t;

    state_t         state;
    logic [5:0]     idx;
    logic [255:0]   hold;
    logic           hex_q;

    state_t         state_n;
    logic [5:0]     idx_n;
    logic [255:0]   hold_n;
    logic           hex_n;
    logic           drop_n;
    logic [7:0]     data_n;
    logic           last_n;

    logic           hs;
    logic           at_last;
    logic           term_on;
    logic           final_hs;
    logic           capture;
    logic [3:0]     nib;
    int unsigned    byte_pos;
    int unsigned    nib_pos;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9)
            return 8'h30 + {4'h0, n};
        else
            return 8'h57 + {4'h0, n};
    endfunction

    // Next-state and next-output logic. Outputs are registered, so the
    // element to present is derived from the *next* index/holding register;
    // this keeps out_ready off any combinational path to the outputs.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        hold_n   = hold;
        hex_n    = hex_q;
        drop_n   = drop_err;
        data_n   = 8'h00;
        last_n   = 1'b0;
        nib      = 4'h0;
        byte_pos = 0;
        nib_pos  = 0;

        hs       = out_valid & out_ready;
        at_last  = hex_q ? (idx == 6'd63) : (idx == 6'd31);
        term_on  = hex_q && (TERM_EN != 0);
        final_hs = hs && (((state == SEND) && at_last && !term_on) || (state == TERM));
        capture  = digest_vld && ((state == IDLE) || final_hs);

        if (digest_vld && (state != IDLE) && !final_hs)
            drop_n = 1'b1;

        case (state)
            SEND: begin
                if (hs) begin
                    if (at_last)
                        state_n = term_on ? TERM : IDLE;
                    else
                        idx_n = idx + 6'd1;
                end
            end
            TERM: begin
                if (hs)
                    state_n = IDLE;
            end
            default: ;
        endcase

        // A digest arriving on the final handshake chains straight into
        // the next frame without passing through IDLE.
        if (capture) begin
            hold_n  = digest_in;
            hex_n   = hex_mode;
            idx_n   = '0;
            state_n = SEND;
        end

        case (state_n)
            SEND: begin
                if (hex_n) begin
                    nib_pos = 255 - 4 * int'(idx_n);
                    nib     = hold_n[nib_pos -: 4];
                    data_n  = hex_char(nib);
                    last_n  = (idx_n == 6'd63) && (TERM_EN == 0);
                end else begin
                    byte_pos = 255 - 8 * int'(idx_n);
                    data_n   = hold_n[byte_pos -: 8];
                    last_n   = (idx_n == 6'd31);
                end
            end
            TERM: begin
                data_n = TERM_CHAR;
                last_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            hold      <= '0;
            hex_q     <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            hold      <= hold_n;
            hex_q     <= hex_n;
            out_data  <= data_n;
            out_valid <= (state_n != IDLE);
            out_last  <= last_n;
            busy      <= (state_n != IDLE);
            drop_err  <= drop_n;
        end
    end

endmodule
